// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-operand and response signals between the ALU command sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the view of the surrounding logic.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_issue;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [OP_W-1:0]   rsp_op;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_zero, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, alu_issue,
    output rsp_valid, rsp_result, rsp_zero, rsp_op, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_zero, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, alu_issue,
    input  rsp_valid, rsp_result, rsp_zero, rsp_op, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers {op,A,B} commands, issues them one at a time to the gated-clock ALU, and returns
// each registered result/zero pair on a valid/ready response channel in command order.
//
// state   | meaning
// S_IDLE  | nothing outstanding; pops the FIFO head as soon as one is present
// S_ISSUE | operands just loaded; alu_issue high for this cycle
// S_WAIT  | timer counts down while the ALU result settles; capture at terminal count
// S_RESP  | response held until rsp_ready; then chain straight to the next command or idle
module alu_cmd_sequencer #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4,
  parameter int LAT    = 2
) (
  input logic gated_clk,
  input logic reset,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CNT_W = $clog2(LAT);
  localparam int ENT_W = OP_W + 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic              r_cmd_ready;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_alu_issue;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;
  logic [OP_W-1:0]   r_rsp_op;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_full_nxt;
  logic [PW-1:0]     w_wr_nxt;
  logic [PW-1:0]     w_rd_nxt;
  logic [ENT_W-1:0]  w_head;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = bus.cmd_valid && r_cmd_ready;
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready));
  assign w_wr_nxt   = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt   = r_rd_ptr + PW'(w_pop);
  assign w_full_nxt = (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) && (w_wr_nxt[AW] != w_rd_nxt[AW]);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge gated_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  // cmd_ready is the registered complement of the post-edge full flag, so it never
  // combinationally follows a same-cycle pop.
  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_cmd_ready <= !w_full_nxt;
    end
  end

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_issue  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_op     <= '0;
    end else begin
      r_alu_issue <= 1'b0;
      if (w_pop) {r_alu_op, r_alu_a, r_alu_b} <= w_head;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state     <= S_ISSUE;
            r_alu_issue <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_W'(LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_zero   <= bus.alu_zero;
            r_rsp_op     <= r_alu_op;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (!w_empty) begin
              r_state     <= S_ISSUE;
              r_alu_issue <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_issue  = r_alu_issue;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_op     = r_rsp_op;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU model, a gateable clock, and a scoreboard
// fed at command acceptance and drained by a monitor at each response handshake.
module tb_alu_cmd_sequencer;
  localparam int LAT = 2;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] result;
    logic       zero;
  } exp_t;

  logic gated_clk = 1'b0;
  logic reset     = 1'b1;
  logic clk_en    = 1'b1;

  alu_cmd_sequencer_if bus_if ();

  alu_cmd_sequencer dut (
    .gated_clk (gated_clk),
    .reset     (reset),
    .bus       (bus_if)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t q[$];
  int   cyc      = 0;
  int   last_cyc = -1;
  int   rsp_cnt  = 0;
  bit   tput_on  = 0;
  bit   hold_vld = 0;
  bit   prev_issue = 0;
  logic [2:0] snap_op;
  logic [3:0] snap_a, snap_b;

  always #5 gated_clk = clk_en ? ~gated_clk : gated_clk;

  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a << 1;
      default: r = a >> 1;
    endcase
    return r;
  endfunction

  // The ALU itself: re-registers its result on every gated clock edge.
  always @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      bus_if.alu_result <= '0;
      bus_if.alu_zero   <= 1'b0;
    end else begin
      bus_if.alu_result <= alu_ref(bus_if.alu_op, bus_if.alu_a, bus_if.alu_b);
      bus_if.alu_zero   <= (alu_ref(bus_if.alu_op, bus_if.alu_a, bus_if.alu_b) == 4'd0);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    n_checks++;
    n_err++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  initial forever begin
    @(posedge reset);
    q.delete();
    hold_vld = 0;
  end

  // Monitor: everything sampled at the negedge reflects what the next posedge will act on.
  initial forever begin
    @(negedge gated_clk);
    cyc++;
    if (!reset) begin
      if (bus_if.alu_issue) begin
        chk("issue_single_cycle", int'(prev_issue), 0);
        snap_op = bus_if.alu_op;
        snap_a  = bus_if.alu_a;
        snap_b  = bus_if.alu_b;
        hold_vld = 1;
      end else if (hold_vld) begin
        chk("operand_a_stable", bus_if.alu_a, snap_a);
        chk("operand_b_stable", bus_if.alu_b, snap_b);
        chk("operand_op_stable", bus_if.alu_op, snap_op);
        if (bus_if.rsp_valid) hold_vld = 0;
      end
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        if (q.size() == 0) begin
          fail_now("rsp_unexpected", "response", "none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_result", bus_if.rsp_result, e.result);
          chk("rsp_zero", bus_if.rsp_zero, e.zero);
          chk("rsp_op", bus_if.rsp_op, e.op);
          if (tput_on && last_cyc >= 0) chk("rsp_interval", cyc - last_cyc, LAT + 2);
          last_cyc = cyc;
        end
        rsp_cnt++;
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        exp_t e;
        e.op     = bus_if.cmd_op;
        e.result = alu_ref(bus_if.cmd_op, bus_if.cmd_a, bus_if.cmd_b);
        e.zero   = (e.result == 4'd0);
        q.push_back(e);
      end
    end
    prev_issue = bus_if.alu_issue;
  end

  // Call at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bit ok = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge gated_clk);
      ok = bus_if.cmd_ready;
      @(posedge gated_clk);
      #2;
    end
    bus_if.cmd_valid = 1'b0;
    if (!ok) fail_now("send_timeout", "no_accept", "accept");
  endtask

  task automatic send_rand();
    send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge gated_clk);
      done = (q.size() == 0) && !bus_if.busy && !bus_if.rsp_valid;
    end
    if (!done) fail_now("drain_timeout", "busy", "idle");
    @(posedge gated_clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus_if.cmd_ready, 1);
    chk({tag, "_alu_op"}, bus_if.alu_op, 0);
    chk({tag, "_alu_a"}, bus_if.alu_a, 0);
    chk({tag, "_alu_b"}, bus_if.alu_b, 0);
    chk({tag, "_alu_issue"}, bus_if.alu_issue, 0);
    chk({tag, "_rsp_valid"}, bus_if.rsp_valid, 0);
    chk({tag, "_rsp_result"}, bus_if.rsp_result, 0);
    chk({tag, "_rsp_zero"}, bus_if.rsp_zero, 0);
    chk({tag, "_rsp_op"}, bus_if.rsp_op, 0);
    chk({tag, "_busy"}, bus_if.busy, 0);
  endtask

  initial begin
    int n;
    int acc;
    int base;
    bit seen;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.rsp_ready = 1'b1;

    #17;
    chk_reset_vals("reset");
    @(posedge gated_clk);
    #2 reset = 1'b0;

    // ADD 7+9 latency from an idle, empty sequencer
    send(3'd0, 4'd7, 4'd9);
    n = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge gated_clk);
      n = i;
      seen = bus_if.rsp_valid;
    end
    chk("latency_edges", n - 1, LAT + 2);
    wait_idle();

    send(3'd1, 4'd2, 4'd3);
    send(3'd5, 4'hF, 4'd0);
    wait_idle();

    // Backpressure: stalled response, continuous commands
    bus_if.rsp_ready = 1'b0;
    base = rsp_cnt;
    acc = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op = 3'($urandom_range(0, 7));
    bus_if.cmd_a  = 4'($urandom_range(0, 15));
    bus_if.cmd_b  = 4'($urandom_range(0, 15));
    for (int i = 0; i < 20; i++) begin
      @(negedge gated_clk);
      if (bus_if.cmd_ready) begin
        acc++;
        @(posedge gated_clk);
        #2;
        bus_if.cmd_op = 3'($urandom_range(0, 7));
        bus_if.cmd_a  = 4'($urandom_range(0, 15));
        bus_if.cmd_b  = 4'($urandom_range(0, 15));
      end else begin
        @(posedge gated_clk);
        #2;
      end
    end
    bus_if.cmd_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready", bus_if.cmd_ready, 0);
    bus_if.rsp_ready = 1'b1;
    wait_idle();
    chk("bp_rsp_count", rsp_cnt - base, 5);

    // Back-to-back stream
    tput_on = 1;
    last_cyc = -1;
    for (int i = 0; i < 12; i++) send_rand();
    wait_idle();
    tput_on = 0;

    // Reset during WAIT with two commands queued
    send_rand();
    send_rand();
    send_rand();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge gated_clk);
    chk_reset_vals("midreset");
    base = rsp_cnt;
    repeat (12) @(negedge gated_clk);
    chk("discarded_no_rsp", rsp_cnt - base, 0);
    @(posedge gated_clk);
    #2;
    send(3'd4, 4'hA, 4'h5);
    wait_idle();
    chk("post_reset_rsp", rsp_cnt - base, 1);

    // Clock stopped during RESP
    bus_if.rsp_ready = 1'b0;
    send(3'd2, 4'hC, 4'h6);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge gated_clk);
      seen = bus_if.rsp_valid;
    end
    chk("gate_rsp_seen", int'(seen), 1);
    clk_en = 1'b0;
    #100;
    clk_en = 1'b1;
    @(posedge gated_clk);
    @(negedge gated_clk);
    chk("gate_rsp_valid", bus_if.rsp_valid, 1);
    if (q.size() > 0) begin
      chk("gate_rsp_result", bus_if.rsp_result, q[0].result);
      chk("gate_rsp_zero", bus_if.rsp_zero, q[0].zero);
      chk("gate_rsp_op", bus_if.rsp_op, q[0].op);
    end else begin
      fail_now("gate_expect", "empty", "one_entry");
    end
    @(posedge gated_clk);
    #2 bus_if.rsp_ready = 1'b1;
    wait_idle();

    // Random traffic with random consumer stalls
    base = rsp_cnt;
    fork
      begin
        for (int i = 0; i < 30; i++) send_rand();
      end
      begin
        repeat (200) begin
          @(posedge gated_clk);
          #2 bus_if.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus_if.rsp_ready = 1'b1;
    wait_idle();
    chk("random_rsp_count", rsp_cnt - base, 30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
